// File: rtl/phys_reg_file_sb.sv
// -----------------------------------------------------------------------------
// phys_reg_file_sb
//   Physical register file with an integrated per-preg ready scoreboard for the
//   out-of-order backend. Rename/dispatch clears ready bits on allocation,
//   execute writeback stores data and sets ready, and a pipeline flush marks
//   every preg ready again. Preg 0 is a hardwired zero that is always ready.
//
// Ports
//   clk        : clock, all state updates on its rising edge
//   rst        : synchronous reset, active-low
//   flush_en   : flush, marks all pregs ready (data retained)
//   rd_addr    : NUM_RD packed read indices
//   rd_data    : NUM_RD packed read values (combinational)
//   rd_ready   : NUM_RD ready bits of the addressed pregs (combinational)
//   wr_en      : NUM_WR writeback valids
//   wr_addr    : NUM_WR packed writeback destinations
//   wr_data    : NUM_WR packed writeback values
//   alloc_en   : NUM_ALLOC allocation valids
//   alloc_addr : NUM_ALLOC packed allocated preg indices
//   busy_cnt   : registered count of not-ready pregs
//
// Handshake: there is no backpressure. wr_en / alloc_en / flush_en are
// single-cycle valids sampled at the rising edge; every asserted request is
// accepted in that cycle.
// -----------------------------------------------------------------------------
module phys_reg_file_sb #(
    parameter int NUM_PREGS = 64,
    parameter int DATA_W    = 32,
    parameter int NUM_RD    = 8,
    parameter int NUM_WR    = 3,
    parameter int NUM_ALLOC = 2,
    parameter int BYPASS    = 1,
    parameter int PREG_W    = $clog2(NUM_PREGS)
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          flush_en,
    input  logic [NUM_RD*PREG_W-1:0]      rd_addr,
    output logic [NUM_RD*DATA_W-1:0]      rd_data,
    output logic [NUM_RD-1:0]             rd_ready,
    input  logic [NUM_WR-1:0]             wr_en,
    input  logic [NUM_WR*PREG_W-1:0]      wr_addr,
    input  logic [NUM_WR*DATA_W-1:0]      wr_data,
    input  logic [NUM_ALLOC-1:0]          alloc_en,
    input  logic [NUM_ALLOC*PREG_W-1:0]   alloc_addr,
    output logic [PREG_W:0]               busy_cnt
);

    logic [DATA_W-1:0]    r_data [NUM_PREGS];
    logic [NUM_PREGS-1:0] r_ready;
    logic [PREG_W:0]      r_busy_cnt;

    logic [NUM_PREGS-1:0] w_ready_nxt;
    logic [PREG_W:0]      w_busy_nxt;

    // Next ready vector. Writes set, allocs clear (alloc applied after writes
    // so it wins), flush sets everything and thereby also discards allocs.
    always_comb begin
        w_ready_nxt = r_ready;
        for (int j = 0; j < NUM_WR; j++) begin
            if (wr_en[j] && (wr_addr[j*PREG_W +: PREG_W] != '0))
                w_ready_nxt[wr_addr[j*PREG_W +: PREG_W]] = 1'b1;
        end
        for (int k = 0; k < NUM_ALLOC; k++) begin
            if (alloc_en[k] && (alloc_addr[k*PREG_W +: PREG_W] != '0))
                w_ready_nxt[alloc_addr[k*PREG_W +: PREG_W]] = 1'b0;
        end
        if (flush_en)
            w_ready_nxt = '1;
        w_ready_nxt[0] = 1'b1;
    end

    // busy_cnt reflects the ready vector as it will be after this edge.
    always_comb begin
        w_busy_nxt = '0;
        for (int p = 1; p < NUM_PREGS; p++)
            w_busy_nxt = w_busy_nxt + (PREG_W+1)'(!w_ready_nxt[p]);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int p = 0; p < NUM_PREGS; p++)
                r_data[p] <= '0;
            r_ready    <= '1;
            r_busy_cnt <= '0;
        end else begin
            // Ascending port order: the highest-index port wins on collisions.
            for (int j = 0; j < NUM_WR; j++) begin
                if (wr_en[j] && (wr_addr[j*PREG_W +: PREG_W] != '0))
                    r_data[wr_addr[j*PREG_W +: PREG_W]] <= wr_data[j*DATA_W +: DATA_W];
            end
            r_ready    <= w_ready_nxt;
            r_busy_cnt <= w_busy_nxt;
        end
    end

    // Combinational read ports with optional same-cycle write forwarding.
    always_comb begin
        logic [PREG_W-1:0] w_ra;
        rd_data  = '0;
        rd_ready = '1;
        w_ra     = '0;
        for (int i = 0; i < NUM_RD; i++) begin
            w_ra = rd_addr[i*PREG_W +: PREG_W];
            rd_data[i*DATA_W +: DATA_W] = r_data[w_ra];
            rd_ready[i]                 = r_ready[w_ra];
            if (BYPASS != 0) begin
                for (int j = 0; j < NUM_WR; j++) begin
                    if (wr_en[j] && (wr_addr[j*PREG_W +: PREG_W] == w_ra)) begin
                        rd_data[i*DATA_W +: DATA_W] = wr_data[j*DATA_W +: DATA_W];
                        rd_ready[i]                 = 1'b1;
                    end
                end
            end
            if ((w_ra == '0) || !rst) begin
                rd_data[i*DATA_W +: DATA_W] = '0;
                rd_ready[i]                 = 1'b1;
            end
        end
    end

    assign busy_cnt = r_busy_cnt;

endmodule

// File: tb/tb_phys_reg_file_sb.sv
module tb_phys_reg_file_sb;

    localparam int NP = 64;
    localparam int DW = 32;
    localparam int NR = 8;
    localparam int NW = 3;
    localparam int NA = 2;
    localparam int PW = 6;

    logic              clk;
    logic              rst;
    logic              flush_en;
    logic [NR*PW-1:0]  rd_addr;
    logic [NW-1:0]     wr_en;
    logic [NW*PW-1:0]  wr_addr;
    logic [NW*DW-1:0]  wr_data;
    logic [NA-1:0]     alloc_en;
    logic [NA*PW-1:0]  alloc_addr;

    logic [NR*DW-1:0]  rd_data_b, rd_data_n;
    logic [NR-1:0]     rd_ready_b, rd_ready_n;
    logic [PW:0]       busy_b, busy_n;

    int n_vec;
    int n_err;

    // Clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    phys_reg_file_sb #(.NUM_PREGS(NP), .DATA_W(DW), .NUM_RD(NR), .NUM_WR(NW),
                       .NUM_ALLOC(NA), .BYPASS(1)) u_byp (
        .clk(clk), .rst(rst), .flush_en(flush_en),
        .rd_addr(rd_addr), .rd_data(rd_data_b), .rd_ready(rd_ready_b),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .alloc_en(alloc_en), .alloc_addr(alloc_addr), .busy_cnt(busy_b)
    );

    phys_reg_file_sb #(.NUM_PREGS(NP), .DATA_W(DW), .NUM_RD(NR), .NUM_WR(NW),
                       .NUM_ALLOC(NA), .BYPASS(0)) u_nob (
        .clk(clk), .rst(rst), .flush_en(flush_en),
        .rd_addr(rd_addr), .rd_data(rd_data_n), .rd_ready(rd_ready_n),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .alloc_en(alloc_en), .alloc_addr(alloc_addr), .busy_cnt(busy_n)
    );

    // Driver tasks
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic clear_in();
        flush_en   = 1'b0;
        wr_en      = '0;
        wr_addr    = '0;
        wr_data    = '0;
        alloc_en   = '0;
        alloc_addr = '0;
    endtask

    task automatic set_rd(input int i, input logic [PW-1:0] a);
        rd_addr[i*PW +: PW] = a;
    endtask

    task automatic set_wr(input int j, input logic [PW-1:0] a, input logic [DW-1:0] d);
        wr_en[j]            = 1'b1;
        wr_addr[j*PW +: PW] = a;
        wr_data[j*DW +: DW] = d;
    endtask

    task automatic set_alloc(input int k, input logic [PW-1:0] a);
        alloc_en[k]            = 1'b1;
        alloc_addr[k*PW +: PW] = a;
    endtask

    // Comparison point
    task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [DW-1:0] dat_b(input int i);
        return rd_data_b[i*DW +: DW];
    endfunction

    function automatic logic [DW-1:0] dat_n(input int i);
        return rd_data_n[i*DW +: DW];
    endfunction

    initial begin
        n_vec   = 0;
        n_err   = 0;
        rst     = 1'b0;
        rd_addr = '0;
        clear_in();

        // 1. Reset with all write ports and allocs active: they must be ignored.
        set_wr(0, 6'd1, 32'h1111_1111);
        set_wr(1, 6'd2, 32'h2222_2222);
        set_wr(2, 6'd3, 32'h3333_3333);
        set_alloc(0, 6'd4);
        set_rd(0, 6'd1);
        set_rd(1, 6'd4);
        settle();
        chk("rst_rd_forced_data", dat_b(0), 32'h0);
        chk("rst_rd_forced_rdy", {31'h0, rd_ready_b[0]}, 32'h1);
        tick();
        tick();
        rst = 1'b1;
        clear_in();
        set_rd(2, 6'd2);
        set_rd(3, 6'd3);
        settle();
        chk("rst_p1_data", dat_b(0), 32'h0);
        chk("rst_p2_data", dat_b(2), 32'h0);
        chk("rst_p3_data_nob", dat_n(3), 32'h0);
        chk("rst_p4_rdy", {31'h0, rd_ready_b[1]}, 32'h1);
        chk("rst_busy", {25'h0, busy_b}, 32'h0);

        // 2/3. Alloc p5 at t, write at t+3.
        set_rd(0, 6'd5);
        set_alloc(0, 6'd5);
        settle();
        chk("alloc_t_rdy_pre", {31'h0, rd_ready_b[0]}, 32'h1);
        tick();
        clear_in();
        settle();
        chk("alloc_t1_rdy", {31'h0, rd_ready_b[0]}, 32'h0);
        chk("alloc_t1_busy", {25'h0, busy_b}, 32'h1);
        chk("alloc_t1_busy_nob", {25'h0, busy_n}, 32'h1);
        tick();
        tick();
        set_wr(0, 6'd5, 32'hDEAD_BEEF);
        settle();
        chk("wr_t3_byp_data", dat_b(0), 32'hDEAD_BEEF);
        chk("wr_t3_byp_rdy", {31'h0, rd_ready_b[0]}, 32'h1);
        chk("wr_t3_nob_data", dat_n(0), 32'h0);
        chk("wr_t3_nob_rdy", {31'h0, rd_ready_n[0]}, 32'h0);
        tick();
        clear_in();
        settle();
        chk("wr_t4_byp_data", dat_b(0), 32'hDEAD_BEEF);
        chk("wr_t4_nob_data", dat_n(0), 32'hDEAD_BEEF);
        chk("wr_t4_nob_rdy", {31'h0, rd_ready_n[0]}, 32'h1);
        chk("wr_t4_busy", {25'h0, busy_b}, 32'h0);

        // 4. Alloc p9 and write p9 on port 2 in the same cycle.
        set_rd(0, 6'd9);
        set_alloc(0, 6'd9);
        set_wr(2, 6'd9, 32'h12);
        settle();
        chk("aw_same_byp_data", dat_b(0), 32'h12);
        chk("aw_same_byp_rdy", {31'h0, rd_ready_b[0]}, 32'h1);
        tick();
        clear_in();
        settle();
        chk("aw_p9_data", dat_b(0), 32'h12);
        chk("aw_p9_rdy", {31'h0, rd_ready_b[0]}, 32'h0);
        chk("aw_busy", {25'h0, busy_b}, 32'h1);

        // 5. Allocs p3,p4 then p7, then flush + alloc p8 + write p3.
        set_alloc(0, 6'd3);
        set_alloc(1, 6'd4);
        tick();
        clear_in();
        set_alloc(1, 6'd7);
        tick();
        clear_in();
        set_rd(0, 6'd3);
        set_rd(1, 6'd4);
        set_rd(2, 6'd7);
        set_rd(3, 6'd8);
        set_rd(4, 6'd9);
        settle();
        chk("pre_flush_busy", {25'h0, busy_b}, 32'h4);
        chk("pre_flush_p3_rdy", {31'h0, rd_ready_b[0]}, 32'h0);
        flush_en = 1'b1;
        set_alloc(0, 6'd8);
        set_wr(1, 6'd3, 32'h55);
        tick();
        clear_in();
        settle();
        chk("flush_rdy_vec", {27'h0, rd_ready_b[4:0]}, 32'h1F);
        chk("flush_p3_data", dat_b(0), 32'h55);
        chk("flush_p3_data_nob", dat_n(0), 32'h55);
        chk("flush_busy", {25'h0, busy_b}, 32'h0);
        chk("flush_p9_kept", dat_b(4), 32'h12);

        // 6. Writes/alloc to p0 dropped; double write to p6, highest port wins.
        set_rd(0, 6'd0);
        set_rd(1, 6'd6);
        set_wr(1, 6'd0, 32'hFFFF_FFFF);
        set_alloc(0, 6'd0);
        set_wr(0, 6'd6, 32'hA);
        set_wr(2, 6'd6, 32'hB);
        settle();
        chk("p0_same_data", dat_b(0), 32'h0);
        chk("p0_same_rdy", {31'h0, rd_ready_b[0]}, 32'h1);
        chk("p6_byp_data", dat_b(1), 32'hB);
        chk("p6_nob_old", dat_n(1), 32'h0);
        tick();
        clear_in();
        settle();
        chk("p0_after_data", dat_b(0), 32'h0);
        chk("p0_after_rdy", {31'h0, rd_ready_b[0]}, 32'h1);
        chk("p6_stored", dat_b(1), 32'hB);
        chk("p6_stored_nob", dat_n(1), 32'hB);
        chk("p0_busy", {25'h0, busy_b}, 32'h0);

        // Duplicate alloc of p10 counts once; a writeback releases it.
        set_alloc(0, 6'd10);
        set_alloc(1, 6'd10);
        tick();
        clear_in();
        settle();
        chk("dup_alloc_busy", {25'h0, busy_b}, 32'h1);
        set_wr(0, 6'd10, 32'h77);
        tick();
        clear_in();
        settle();
        chk("dup_release_busy", {25'h0, busy_n}, 32'h0);

        // Mid-run reset clears stored data and busy state.
        set_alloc(0, 6'd11);
        tick();
        clear_in();
        rst = 1'b0;
        tick();
        rst = 1'b1;
        settle();
        chk("rerst_p6_data", dat_b(1), 32'h0);
        chk("rerst_busy", {25'h0, busy_b}, 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
